ctrl_seq: RTL and testbench
===========================

# ctrl_seq

Multi-cycle control sequencer for the 8-bit RISC core. It fetches 8-bit instructions over a req/ack memory handshake and decodes them into the 3-bit ALU control code and operand addresses. It then sequences register-file write-back, capturing the ALU carry/overflow as a flag. It sits between instruction memory and the datapath: register file plus ALU.

## Interface
- No parameters. Data width fixed at 8, register file at 4 entries.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `run` in 1: start execution; sampled only in IDLE.
- `imem_req` out 1: fetch request.
- `imem_addr` out 8: fetch address (= `pc`).
- `imem_rdata` in 8: instruction/immediate byte; valid when `imem_ack`=1.
- `imem_ack` in 1: fetch complete; ignored when `imem_req`=0.
- `rf_raddr1` out 2: ALU operand A register (= rd).
- `rf_raddr2` out 2: ALU operand B register.
- `alu_ctrl` out 3: ALU operation code.
- `alu_overflow` in 1: ALU carry-out.
- `rf_we` out 1: register write strobe, one cycle.
- `rf_waddr` out 2: write register.
- `rf_wsel` out 1: write-data select; 0=ALU out, 1=`imm`.
- `imm` out 8: latched immediate byte.
- `pc` out 8: program counter.
- `flag_c` out 1: carry/overflow of last ADD/SUB.
- `halted` out 1: core stopped (HALT or illegal).
- `illegal` out 1: sticky illegal-instruction flag.

## Operation
- Instruction format: [7:5] opcode, [4] reserved (must be 0), [3:2] rd (also rs1), [1:0] rs2.
- Opcodes, with the ALU ctrl they drive:
  - 000 ADD → 000.
  - 001 SUB → 001.
  - 010 SHR → 010.
  - 011 NOR → 011.
  - 100 NAND → 100.
  - 101 SHL → 101.
  - 110 LI: rd ← next byte.
  - 111 HALT.
- Any opcode with [4]=1 is illegal: set `illegal`, enter HALT, no register write.
- States:
  - IDLE: `run`=1 → FETCH.
  - FETCH: `imem_req`=1. On `imem_ack`: IR ← `imem_rdata`, pc ← pc+1, → DECODE.
  - DECODE: drive `rf_raddr1`/`rf_raddr2`/`alu_ctrl` from IR. ALU op → WB. LI → IMM. HALT/illegal → HALT.
  - IMM: `imem_req`=1. On ack: imm ← `imem_rdata`, pc ← pc+1, → WB.
  - WB: `rf_we`=1, `rf_waddr`=rd, `rf_wsel`=(LI), → FETCH.
  - HALT: `halted`=1; exit only via reset.
- `flag_c` ← `alu_overflow` in WB for ADD/SUB only. SHR/NOR/NAND/SHL/LI leave it unchanged.
- `alu_ctrl`, `rf_raddr1`, `rf_raddr2` hold their values through DECODE and WB, so the ALU result is stable at the write edge. In other states they drive 000/0/0.
- pc wraps 0xFF→0x00 silently. Execution continues.

## Timing
- Reset (`rst_n`=0 at a rising edge) forces:
  - state IDLE;
  - all outputs 0: `pc`=0, `imm`=0, `flag_c`=0, `illegal`=0, `halted`=0, `imem_req`=0, `rf_we`=0.
- Reset mid-fetch drops `imem_req` on that same edge. An `imem_ack` arriving during or after reset is ignored.
- `imem_req` rises the cycle after entry to FETCH/IMM. It stays high until the edge where ack is sampled, and falls the next cycle.
- Zero-wait memory (ack in the first req cycle) gives:
  - ALU instruction: 3 cycles (FETCH, DECODE, WB).
  - LI: 4 cycles.
  - Each ack wait cycle adds 1.
- `rf_we` is high for exactly one cycle per ALU/LI instruction, never for HALT/illegal.
- `halted` asserts the cycle after DECODE of HALT/illegal and stays high.
- `run` is a don't-care outside IDLE.

## Structure
- Package `ctrl_pkg` holds:
  - opcode enum;
  - ALU ctrl localparams (shared with the ALU, so encodings have one source);
  - FSM state enum;
  - field-slice constants (OPC_MSB/LSB, RD, RS2).
- Sub-module `ctrl_decode` (combinational): IR → {alu_ctrl, is_li, is_halt, is_illegal, updates_flag}.
- Top holds the FSM, pc, IR, imm, flags.

## Test plan
- Reset then `run`=1, memory [0x00]=0x06 (ADD r1,r2), zero-wait → `imem_addr`=0x00 ack, `alu_ctrl`=000, `rf_raddr1`=1, `rf_raddr2`=2, then `rf_we`=1 with `rf_waddr`=1 and `rf_wsel`=0 on cycle 3; `pc`=0x01.
- LI r3,0xA5 (bytes 0xCC, 0xA5), ack delayed 2 cycles each → `imm`=0xA5, `rf_waddr`=3, `rf_wsel`=1, `pc`=0x02, total 8 cycles.
- SUB with `alu_overflow`=1, then SHL with `alu_overflow`=0 → `flag_c`=1 after SUB and still 1 after SHL.
- Instruction 0x10 → `illegal`=1, `halted`=1, no `rf_we`, `imem_req` never reasserts; `run` pulses are ignored.
- `pc` at 0xFF fetching ADD → `pc`=0x00 and the next fetch is at address 0x00.
- `rst_n`=0 while `imem_req`=1 and ack pending → next cycle all outputs 0, state IDLE; a late ack is ignored.

Source files
------------

// File: rtl/ctrl_seq_pkg.sv
// Shared definitions for the 8-bit core control sequencer: opcodes,
// ALU control encodings, FSM states and instruction field positions.
package ctrl_pkg;

  localparam int DATA_W = 8;
  localparam int RF_AW  = 2;

  localparam int OPC_MSB = 7;
  localparam int OPC_LSB = 5;
  localparam int RSV_BIT = 4;
  localparam int RD_MSB  = 3;
  localparam int RD_LSB  = 2;
  localparam int RS2_MSB = 1;
  localparam int RS2_LSB = 0;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_SHR  = 3'b010,
    OP_NOR  = 3'b011,
    OP_NAND = 3'b100,
    OP_SHL  = 3'b101,
    OP_LI   = 3'b110,
    OP_HALT = 3'b111
  } opcode_e;

  // ALU control codes; the ALU imports these so both sides agree.
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_SHR  = 3'b010;
  localparam logic [2:0] ALU_NOR  = 3'b011;
  localparam logic [2:0] ALU_NAND = 3'b100;
  localparam logic [2:0] ALU_SHL  = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_IMM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  // Non-ALU opcodes (LI, HALT) map to the ADD code so the ALU input is benign.
  function automatic logic [2:0] alu_ctrl_of(opcode_e op);
    logic [2:0] code;
    case (op)
      OP_ADD:  code = ALU_ADD;
      OP_SUB:  code = ALU_SUB;
      OP_SHR:  code = ALU_SHR;
      OP_NOR:  code = ALU_NOR;
      OP_NAND: code = ALU_NAND;
      OP_SHL:  code = ALU_SHL;
      default: code = ALU_ADD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/ctrl_seq_if.sv
// Instruction-memory req/ack handshake between the sequencer and memory.
interface ctrl_seq_if;

  logic       req;
  logic [7:0] addr;
  logic [7:0] rdata;
  logic       ack;

  modport master (
    output req,
    output addr,
    input  rdata,
    input  ack
  );

  modport slave (
    input  req,
    input  addr,
    output rdata,
    output ack
  );

endinterface

// File: rtl/ctrl_seq_decode.sv
// Combinational instruction decoder: splits the instruction register into
// ALU control, register fields and instruction-class flags.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [7:0] ir_i,
  output logic [2:0] alu_ctrl_o,
  output logic [1:0] rd_o,
  output logic [1:0] rs2_o,
  output logic       is_li_o,
  output logic       is_halt_o,
  output logic       is_illegal_o,
  output logic       updates_flag_o
);

  opcode_e opc;

  assign opc   = opcode_e'(ir_i[OPC_MSB:OPC_LSB]);
  assign rd_o  = ir_i[RD_MSB:RD_LSB];
  assign rs2_o = ir_i[RS2_MSB:RS2_LSB];

  // A set reserved bit overrides every opcode, so illegal wins over LI/HALT/ALU.
  always_comb begin
    is_illegal_o   = ir_i[RSV_BIT];
    is_li_o        = 1'b0;
    is_halt_o      = 1'b0;
    updates_flag_o = 1'b0;
    alu_ctrl_o     = alu_ctrl_of(opc);
    if (!ir_i[RSV_BIT]) begin
      is_li_o        = (opc == OP_LI);
      is_halt_o      = (opc == OP_HALT);
      updates_flag_o = (opc == OP_ADD) || (opc == OP_SUB);
    end
  end

endmodule

// File: rtl/ctrl_seq.sv
// Multi-cycle control sequencer: fetches instructions over the memory
// handshake, decodes them, and sequences register-file write-back.
module ctrl_seq
  import ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  ctrl_seq_if.master       imem,
  output logic [1:0]       rf_raddr1,
  output logic [1:0]       rf_raddr2,
  output logic [2:0]       alu_ctrl,
  input  logic             alu_overflow,
  output logic             rf_we,
  output logic [1:0]       rf_waddr,
  output logic             rf_wsel,
  output logic [7:0]       imm,
  output logic [7:0]       pc,
  output logic             flag_c,
  output logic             halted,
  output logic             illegal
);

  state_e     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] imm_q, imm_d;
  logic       flag_c_q, flag_c_d;
  logic       illegal_q, illegal_d;

  logic [2:0] dec_alu_ctrl;
  logic [1:0] dec_rd;
  logic [1:0] dec_rs2;
  logic       dec_is_li;
  logic       dec_is_halt;
  logic       dec_is_illegal;
  logic       dec_updates_flag;

  ctrl_decode u_decode (
    .ir_i           (ir_q),
    .alu_ctrl_o     (dec_alu_ctrl),
    .rd_o           (dec_rd),
    .rs2_o          (dec_rs2),
    .is_li_o        (dec_is_li),
    .is_halt_o      (dec_is_halt),
    .is_illegal_o   (dec_is_illegal),
    .updates_flag_o (dec_updates_flag)
  );

  // State register; reset returns the sequencer to IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; HALT is only left through reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem.ack) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (dec_is_illegal || dec_is_halt) state_d = ST_HALT;
        else if (dec_is_li)                state_d = ST_IMM;
        else                               state_d = ST_WB;
      end
      ST_IMM: begin
        if (imem.ack) state_d = ST_WB;
      end
      ST_WB: begin
        state_d = ST_FETCH;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath next values: IR/imm capture on ack, pc advance, flag and sticky illegal.
  always_comb begin
    pc_d      = pc_q;
    ir_d      = ir_q;
    imm_d     = imm_q;
    flag_c_d  = flag_c_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_FETCH: begin
        if (imem.ack) begin
          ir_d = imem.rdata;
          pc_d = pc_q + 8'd1;
        end
      end
      ST_IMM: begin
        if (imem.ack) begin
          imm_d = imem.rdata;
          pc_d  = pc_q + 8'd1;
        end
      end
      ST_DECODE: begin
        if (dec_is_illegal) illegal_d = 1'b1;
      end
      ST_WB: begin
        if (dec_updates_flag) flag_c_d = alu_overflow;
      end
      default: begin
      end
    endcase
  end

  // Datapath registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q      <= 8'h00;
      ir_q      <= 8'h00;
      imm_q     <= 8'h00;
      flag_c_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      imm_q     <= imm_d;
      flag_c_q  <= flag_c_d;
      illegal_q <= illegal_d;
    end
  end

  // Moore outputs; operand addresses and ALU code hold across DECODE and WB
  // so the ALU result is settled when the register file writes.
  always_comb begin
    imem.req  = 1'b0;
    rf_raddr1 = 2'd0;
    rf_raddr2 = 2'd0;
    alu_ctrl  = 3'd0;
    rf_we     = 1'b0;
    rf_waddr  = 2'd0;
    rf_wsel   = 1'b0;
    halted    = 1'b0;
    case (state_q)
      ST_FETCH, ST_IMM: begin
        imem.req = 1'b1;
      end
      ST_DECODE: begin
        rf_raddr1 = dec_rd;
        rf_raddr2 = dec_rs2;
        alu_ctrl  = dec_alu_ctrl;
      end
      ST_WB: begin
        rf_raddr1 = dec_rd;
        rf_raddr2 = dec_rs2;
        alu_ctrl  = dec_alu_ctrl;
        rf_we     = 1'b1;
        rf_waddr  = dec_rd;
        rf_wsel   = dec_is_li;
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign imem.addr = pc_q;
  assign pc        = pc_q;
  assign imm       = imm_q;
  assign flag_c    = flag_c_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed testbench for ctrl_seq: memory model with programmable ack delay,
// write-back scoreboard, immediate-assertion checks.
module tb_ctrl_seq;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic [1:0] rf_raddr1;
  logic [1:0] rf_raddr2;
  logic [2:0] alu_ctrl;
  logic       alu_overflow;
  logic       rf_we;
  logic [1:0] rf_waddr;
  logic       rf_wsel;
  logic [7:0] imm;
  logic [7:0] pc;
  logic       flag_c;
  logic       halted;
  logic       illegal;

  ctrl_seq_if imem_if ();

  ctrl_seq dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .imem         (imem_if),
    .rf_raddr1    (rf_raddr1),
    .rf_raddr2    (rf_raddr2),
    .alu_ctrl     (alu_ctrl),
    .alu_overflow (alu_overflow),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wsel      (rf_wsel),
    .imm          (imm),
    .pc           (pc),
    .flag_c       (flag_c),
    .halted       (halted),
    .illegal      (illegal)
  );

  typedef struct packed {
    logic [1:0] waddr;
    logic       wsel;
    logic [7:0] imm;
  } wr_t;

  wr_t        expq[$];
  logic [7:0] mem [256];
  int         ackDelay;
  int         waitCnt;
  logic       forceAck;
  int         nChecks;
  int         nFails;

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory responder: acks after ackDelay wait cycles, updated on the falling edge.
  always @(negedge clk) begin
    if (forceAck) begin
      imem_if.ack   = 1'b1;
      imem_if.rdata = 8'hFF;
    end else if (imem_if.req === 1'b1) begin
      if (waitCnt >= ackDelay) begin
        imem_if.ack   = 1'b1;
        imem_if.rdata = mem[imem_if.addr];
        waitCnt       = 0;
      end else begin
        imem_if.ack = 1'b0;
        waitCnt     = waitCnt + 1;
      end
    end else begin
      imem_if.ack = 1'b0;
      waitCnt     = 0;
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int delay);
    ackDelay = delay;
  endtask

  task automatic expectWrite(input logic [1:0] waddr, input logic wsel, input logic [7:0] immv);
    wr_t e;
    e.waddr = waddr;
    e.wsel  = wsel;
    e.imm   = immv;
    expq.push_back(e);
  endtask

  task automatic doReset();
    rst_n    = 1'b0;
    run      = 1'b0;
    forceAck = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    expq.delete();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic waitWrite(input string tag, input int maxCycles, output int cycles);
    wr_t e;
    bit  seen;
    seen   = 1'b0;
    cycles = 0;
    for (int i = 1; i <= maxCycles; i++) begin
      step();
      if (rf_we === 1'b1) begin
        cycles = i;
        seen   = 1'b1;
        break;
      end
    end
    checkOutput({tag, "_we_seen"}, 16'(seen), 16'h1);
    if (seen) begin
      checkOutput({tag, "_sb_nonempty"}, 16'(expq.size() != 0), 16'h1);
      if (expq.size() != 0) begin
        e = expq.pop_front();
        checkOutput({tag, "_waddr"}, 16'(rf_waddr), 16'(e.waddr));
        checkOutput({tag, "_wsel"}, 16'(rf_wsel), 16'(e.wsel));
        if (e.wsel) checkOutput({tag, "_imm"}, 16'(imm), 16'(e.imm));
      end
    end
  endtask

  // Directed sequence of scenarios.
  initial begin
    int  cyc;
    int  weSeen;
    int  reqSeen;
    bit  found;
    nChecks       = 0;
    nFails        = 0;
    waitCnt       = 0;
    ackDelay      = 0;
    forceAck      = 1'b0;
    alu_overflow  = 1'b0;
    imem_if.ack   = 1'b0;
    imem_if.rdata = 8'h00;

    doReset();
    rst_n = 1'b0;
    step();
    checkOutput("rst_req", 16'(imem_if.req), 16'h0);
    checkOutput("rst_pc", 16'(pc), 16'h0);
    checkOutput("rst_imm", 16'(imm), 16'h0);
    checkOutput("rst_flags", 16'({flag_c, illegal, halted, rf_we}), 16'h0);

    // ADD r1,r2 with zero-wait memory.
    mem[0] = 8'h06;
    applyStimulus(0);
    rst_n = 1'b1;
    run   = 1'b1;
    step();
    checkOutput("add_fetch_req", 16'(imem_if.req), 16'h1);
    checkOutput("add_fetch_addr", 16'(imem_if.addr), 16'h00);
    run = 1'b0;
    step();
    checkOutput("add_dec_ctrl", 16'({alu_ctrl, rf_raddr1, rf_raddr2}), 16'({3'b000, 2'd1, 2'd2}));
    checkOutput("add_dec_we", 16'(rf_we), 16'h0);
    checkOutput("add_dec_pc", 16'(pc), 16'h01);
    expectWrite(2'd1, 1'b0, 8'h00);
    waitWrite("add", 4, cyc);
    checkOutput("add_wb_cycle", 16'(cyc), 16'd1);
    checkOutput("add_wb_ctrl", 16'({alu_ctrl, rf_raddr1, rf_raddr2}), 16'({3'b000, 2'd1, 2'd2}));
    step();
    checkOutput("add_next_addr", 16'({imem_if.req, imem_if.addr}), 16'({1'b1, 8'h01}));

    // LI r3,0xA5 with two wait cycles per access.
    doReset();
    mem[0] = 8'hCC;
    mem[1] = 8'hA5;
    applyStimulus(2);
    expectWrite(2'd3, 1'b1, 8'hA5);
    run = 1'b1;
    waitWrite("li", 20, cyc);
    run = 1'b0;
    checkOutput("li_cycles", 16'(cyc), 16'd8);
    checkOutput("li_pc", 16'(pc), 16'h02);
    checkOutput("li_imm", 16'(imm), 16'hA5);

    // SUB with overflow sets flag_c; SHL without overflow leaves it.
    doReset();
    mem[0] = 8'h26;
    mem[1] = 8'hA7;
    mem[2] = 8'hE0;
    applyStimulus(0);
    alu_overflow = 1'b1;
    expectWrite(2'd1, 1'b0, 8'h00);
    run = 1'b1;
    waitWrite("sub", 6, cyc);
    run = 1'b0;
    checkOutput("sub_alu_ctrl", 16'(alu_ctrl), 16'h1);
    step();
    alu_overflow = 1'b0;
    checkOutput("sub_flag_c", 16'(flag_c), 16'h1);
    expectWrite(2'd1, 1'b0, 8'h00);
    waitWrite("shl", 6, cyc);
    checkOutput("shl_alu_ctrl", 16'({alu_ctrl, rf_raddr2}), 16'({3'b101, 2'd3}));
    step();
    checkOutput("shl_flag_c", 16'(flag_c), 16'h1);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (halted === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("halt_reached", 16'(found), 16'h1);
    checkOutput("halt_not_illegal", 16'(illegal), 16'h0);

    // Illegal instruction (reserved bit set).
    doReset();
    mem[0] = 8'h10;
    applyStimulus(0);
    weSeen  = 0;
    reqSeen = 0;
    run = 1'b1;
    step();
    run = 1'b0;
    step();
    checkOutput("ill_dec_halted", 16'(halted), 16'h0);
    if (rf_we === 1'b1) weSeen++;
    step();
    checkOutput("ill_halted", 16'({halted, illegal}), 16'h3);
    for (int i = 0; i < 12; i++) begin
      run = i[0];
      step();
      if (rf_we === 1'b1) weSeen++;
      if (imem_if.req === 1'b1) reqSeen++;
    end
    run = 1'b0;
    checkOutput("ill_no_we", 16'(weSeen), 16'h0);
    checkOutput("ill_no_req", 16'(reqSeen), 16'h0);
    checkOutput("ill_sticky", 16'({halted, illegal}), 16'h3);

    // pc wrap 0xFF -> 0x00.
    doReset();
    mem[8'hFF] = 8'h06;
    applyStimulus(0);
    run   = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (imem_if.req === 1'b1 && imem_if.addr === 8'hFF) begin
        found = 1'b1;
        break;
      end
    end
    run = 1'b0;
    checkOutput("wrap_reach_ff", 16'(found), 16'h1);
    expectWrite(2'd1, 1'b0, 8'h00);
    waitWrite("wrap", 5, cyc);
    checkOutput("wrap_pc", 16'(pc), 16'h00);
    step();
    checkOutput("wrap_next_addr", 16'({imem_if.req, imem_if.addr}), 16'({1'b1, 8'h00}));

    // Reset while a fetch is pending; a late ack must be ignored.
    doReset();
    mem[0] = 8'h06;
    applyStimulus(100);
    run = 1'b1;
    step();
    step();
    checkOutput("mid_req_pending", 16'(imem_if.req), 16'h1);
    rst_n = 1'b0;
    run   = 1'b0;
    step();
    checkOutput("mid_rst_req", 16'(imem_if.req), 16'h0);
    checkOutput("mid_rst_outs", 16'({pc, imm}), 16'h0000);
    checkOutput("mid_rst_flags", 16'({flag_c, illegal, halted, rf_we}), 16'h0);
    rst_n    = 1'b1;
    forceAck = 1'b1;
    step();
    step();
    step();
    forceAck = 1'b0;
    checkOutput("late_ack_req", 16'(imem_if.req), 16'h0);
    checkOutput("late_ack_pc", 16'(pc), 16'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
